// File: rtl/vscale_md_requester.sv
// vscale_md_requester: decodes RV32M ops, issues one request to the iterative mul/div unit and returns its result
module vscale_md_requester #(
  parameter int XPR_LEN          = 32,
  parameter int MD_OP_WIDTH      = 2,
  parameter int MD_OUT_SEL_WIDTH = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cmd_valid_i,
  input  logic [2:0]                  cmd_funct3_i,
  input  logic [XPR_LEN-1:0]          cmd_rs1_i,
  input  logic [XPR_LEN-1:0]          cmd_rs2_i,
  input  logic                        cmd_kill_i,
  output logic                        stall_o,
  output logic                        result_valid_o,
  output logic [XPR_LEN-1:0]          result_o,
  output logic                        md_req_valid_o,
  input  logic                        md_req_ready_i,
  output logic [MD_OP_WIDTH-1:0]      md_req_op_o,
  output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel_o,
  output logic                        md_req_in_1_signed_o,
  output logic                        md_req_in_2_signed_o,
  output logic [XPR_LEN-1:0]          md_req_in_1_o,
  output logic [XPR_LEN-1:0]          md_req_in_2_o,
  input  logic                        md_resp_valid_i,
  input  logic [XPR_LEN-1:0]          md_resp_result_i
);
  localparam logic [MD_OP_WIDTH-1:0]      MD_OP_MUL  = MD_OP_WIDTH'(0);
  localparam logic [MD_OP_WIDTH-1:0]      MD_OP_DIV  = MD_OP_WIDTH'(1);
  localparam logic [MD_OP_WIDTH-1:0]      MD_OP_REM  = MD_OP_WIDTH'(2);
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = MD_OUT_SEL_WIDTH'(0);
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = MD_OUT_SEL_WIDTH'(1);
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = MD_OUT_SEL_WIDTH'(2);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t                        state_q;
  logic [MD_OP_WIDTH-1:0]        op_q, op_d;
  logic [MD_OUT_SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                          s1_q, s1_d, s2_q, s2_d;
  logic [XPR_LEN-1:0]            in1_q, in2_q, result_q;

  always_comb begin
    op_d  = cmd_funct3_i[2] ? (cmd_funct3_i[1] ? MD_OP_REM : MD_OP_DIV) : MD_OP_MUL;
    sel_d = cmd_funct3_i[2] ? (cmd_funct3_i[1] ? MD_OUT_REM : MD_OUT_LO)
                            : (cmd_funct3_i[1:0] == 2'd0 ? MD_OUT_LO : MD_OUT_HI);
    s1_d  = cmd_funct3_i[2] ? ~cmd_funct3_i[0] : (cmd_funct3_i[1:0] != 2'd3);
    s2_d  = cmd_funct3_i[2] ? ~cmd_funct3_i[0] : ~cmd_funct3_i[1];
  end

  // The unit cannot abort, so a kill after transfer must drain its response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sel_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid_i && !cmd_kill_i) begin
          op_q    <= op_d;
          sel_q   <= sel_d;
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          in1_q   <= cmd_rs1_i;
          in2_q   <= cmd_rs2_i;
          state_q <= S_REQ;
        end
        S_REQ: state_q <= cmd_kill_i ? S_IDLE : (md_req_ready_i ? S_WAIT : S_REQ);
        S_WAIT: if (cmd_kill_i) begin
          state_q <= md_resp_valid_i ? S_IDLE : S_DRAIN;
        end else if (md_resp_valid_i) begin
          result_q <= md_resp_result_i;
          state_q  <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        S_DRAIN: state_q <= md_resp_valid_i ? S_IDLE : S_DRAIN;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o              = cmd_valid_i && !cmd_kill_i && (state_q != S_DONE);
  assign result_valid_o       = (state_q == S_DONE);
  assign result_o             = result_q;
  assign md_req_valid_o       = (state_q == S_REQ) && !cmd_kill_i;
  assign md_req_op_o          = op_q;
  assign md_req_out_sel_o     = sel_q;
  assign md_req_in_1_signed_o = s1_q;
  assign md_req_in_2_signed_o = s2_q;
  assign md_req_in_1_o        = in1_q;
  assign md_req_in_2_o        = in2_q;
endmodule

// File: tb/tb_vscale_md_requester.sv
// tb_vscale_md_requester: randomized and directed checks of the M-op requester against a behavioural model with a fake mul/div unit
module tb_vscale_md_requester;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_DONE = 3, P_DRAIN = 4;

  logic        clk = 0, reset = 1;
  logic        cmd_valid = 0, cmd_kill = 0;
  logic [2:0]  cmd_funct3 = 0;
  logic [31:0] cmd_rs1 = 0, cmd_rs2 = 0;
  logic        md_req_ready = 0, md_resp_valid = 0;
  logic [31:0] md_resp_result = 0;
  logic        stall, result_valid, md_req_valid, s1, s2;
  logic [31:0] result, in1, in2;
  logic [1:0]  op, sel;

  always #5 clk = ~clk;

  vscale_md_requester dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_funct3_i(cmd_funct3),
    .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_kill_i(cmd_kill), .stall_o(stall),
    .result_valid_o(result_valid), .result_o(result), .md_req_valid_o(md_req_valid),
    .md_req_ready_i(md_req_ready), .md_req_op_o(op), .md_req_out_sel_o(sel),
    .md_req_in_1_signed_o(s1), .md_req_in_2_signed_o(s2), .md_req_in_1_o(in1),
    .md_req_in_2_o(in2), .md_resp_valid_i(md_resp_valid), .md_resp_result_i(md_resp_result)
  );

  int errors = 0, checks = 0, pulses = 0;
  int rdy_mode = 1, lat_cfg = 0;
  int m_ph = P_IDLE, u_cnt = 0;
  logic [1:0]  m_op = 0, m_sel = 0;
  logic        m_s1 = 0, m_s2 = 0;
  logic [31:0] m_a = 0, m_b = 0, m_res = 0, m_exp = 0, u_res = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dec(input logic [2:0] f);
    case (f)
      3'd0: return {2'd0, 2'd0, 2'b11};
      3'd1: return {2'd0, 2'd1, 2'b11};
      3'd2: return {2'd0, 2'd1, 2'b10};
      3'd3: return {2'd0, 2'd1, 2'b00};
      3'd4: return {2'd1, 2'd0, 2'b11};
      3'd5: return {2'd1, 2'd0, 2'b00};
      3'd6: return {2'd2, 2'd2, 2'b11};
      default: return {2'd2, 2'd2, 2'b00};
    endcase
  endfunction

  // What the mul/div unit returns for a request's fields.
  function automatic logic [31:0] unit_calc(input logic [1:0] o, input logic [1:0] sl,
      input logic sa, input logic sb, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p, q, r;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    p = x * y;
    if (o == 2'd0) return sl == 2'd1 ? p[63:32] : p[31:0];
    if (b == 0) return o == 2'd1 ? 32'hFFFFFFFF : a;
    q = x / y;
    r = x % y;
    return o == 2'd1 ? q[31:0] : r[31:0];
  endfunction

  // Architectural RV32M result from funct3 and operands.
  function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] ma, mb, q, r;
    logic sg;
    if (f < 4) begin
      ea = {{32{a[31] & (f != 3)}}, a};
      eb = {{32{b[31] & (f < 2)}}, b};
      p = ea * eb;
      return f == 0 ? p[31:0] : p[63:32];
    end
    if (b == 0) return f < 6 ? 32'hFFFFFFFF : a;
    sg = (f == 4) || (f == 6);
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (sg && (a[31] ^ b[31])) q = -q;
    if (sg && a[31]) r = -r;
    return f < 6 ? q : r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = P_IDLE; m_op = 0; m_sel = 0; m_s1 = 0; m_s2 = 0;
      m_a = 0; m_b = 0; m_res = 0; u_cnt = 0;
      md_resp_valid <= 0;
      md_req_ready <= 0;
    end else begin
      md_resp_valid <= 0;
      md_resp_result <= $urandom;
      if (m_ph == P_REQ && !cmd_kill && md_req_ready) begin
        u_cnt = lat_cfg != 0 ? lat_cfg : int'($urandom_range(1, 6));
        u_res = unit_calc(m_op, m_sel, m_s1, m_s2, m_a, m_b);
      end else if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin
          md_resp_valid <= 1;
          md_resp_result <= u_res;
        end
      end
      md_req_ready <= rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      case (m_ph)
        P_IDLE: if (cmd_valid && !cmd_kill) begin
          {m_op, m_sel, m_s1, m_s2} = dec(cmd_funct3);
          m_a = cmd_rs1; m_b = cmd_rs2;
          m_exp = rv32m(cmd_funct3, cmd_rs1, cmd_rs2);
          m_ph = P_REQ;
        end
        P_REQ:  m_ph = cmd_kill ? P_IDLE : md_req_ready ? P_WAIT : P_REQ;
        P_WAIT: if (cmd_kill) m_ph = md_resp_valid ? P_IDLE : P_DRAIN;
                else if (md_resp_valid) begin m_res = md_resp_result; m_ph = P_DONE; end
        P_DONE: m_ph = P_IDLE;
        default: if (md_resp_valid) m_ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(cmd_valid & ~cmd_kill & (m_ph != P_DONE)));
    chk("result_valid", 32'(result_valid), 32'(m_ph == P_DONE));
    chk("req_valid", 32'(md_req_valid), 32'((m_ph == P_REQ) & ~cmd_kill));
    chk("result", result, m_res);
    chk("req_op", 32'(op), 32'(m_op));
    chk("req_sel", 32'(sel), 32'(m_sel));
    chk("req_s1", 32'(s1), 32'(m_s1));
    chk("req_s2", 32'(s2), 32'(m_s2));
    chk("req_in1", in1, m_a);
    chk("req_in2", in2, m_b);
    if (m_ph == P_DONE && !reset) chk("rv32m", result, m_exp);
    if (result_valid) pulses++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1; cmd_funct3 = f; cmd_rs1 = a; cmd_rs2 = b;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!md_req_valid && n < 40) begin @(negedge clk); n++; end
    if (!md_req_valid) chk({name, "_req_timeout"}, 0, 1);
  endtask

  task automatic wait_phase(input string name, input int p);
    int n = 0;
    while (m_ph != p && n < 40) begin @(negedge clk); n++; end
    if (m_ph != p) chk({name, "_phase_timeout"}, 32'(m_ph), 32'(p));
  endtask

  task automatic wait_result(input string name, input logic [31:0] expd);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = result_valid;
    end
    if (seen) begin
      chk(name, result, expd);
      chk({name, "_stall_done"}, 32'(stall), 0);
    end else chk({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int p0;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_req_valid", 32'(md_req_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_in1", in1, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    step();
    lat_cfg = 3;
    // MULH, stall from accept until DONE, single result pulse
    p0 = pulses;
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    chk("mulh_stall_accept", 32'(stall), 1);
    wait_result("mulh", 32'hFFFFFFFF);
    step(); step();
    chk("mulh_pulses", 32'(pulses - p0), 1);
    issue(3'd5, 32'd100, 32'd7); wait_result("divu", 32'd14); step();
    issue(3'd7, 32'd100, 32'd7); wait_result("remu", 32'd2); step();
    issue(3'd6, -32'sd7, 32'd2); wait_result("rem", 32'hFFFFFFFF); step();
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_req("mulhsu");
    chk("mulhsu_s1", 32'(s1), 1);
    chk("mulhsu_s2", 32'(s2), 0);
    wait_result("mulhsu", 32'hFFFFFFFF); step();
    // Unit back-pressure: request fields must hold while cmd inputs wander
    rdy_mode = 2;
    issue(3'd5, 32'd100, 32'd7);
    wait_req("hold");
    for (int i = 0; i < 5; i++) begin
      step();
      cmd_rs1 = $urandom; cmd_rs2 = $urandom; cmd_funct3 = 3'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(md_req_valid), 1);
      chk("hold_in1", in1, 32'd100);
      chk("hold_in2", in2, 32'd7);
      chk("hold_op", 32'(op), 1);
      chk("hold_sel", 32'(sel), 0);
    end
    rdy_mode = 1;
    wait_result("hold_divu", 32'd14); step();
    // Kill in WAIT, then a new MUL waits through DRAIN
    lat_cfg = 5;
    issue(3'd0, 32'd3, 32'd5);
    wait_phase("kill", P_WAIT);
    #1 cmd_kill = 1;
    step();
    cmd_kill = 0;
    p0 = pulses;
    issue(3'd0, 32'd6, 32'd7);
    @(negedge clk);
    chk("drain_stall", 32'(stall), 1);
    chk("drain_result_valid", 32'(result_valid), 0);
    wait_result("kill_mul", 32'd42);
    step();
    chk("kill_pulses", 32'(pulses - p0), 1);
    // Asynchronous reset in the middle of WAIT
    issue(3'd4, 32'd50, 32'd5);
    wait_phase("areset", P_WAIT);
    #2 reset = 1; cmd_valid = 0;
    #1;
    chk("areset_stall", 32'(stall), 0);
    chk("areset_result_valid", 32'(result_valid), 0);
    chk("areset_req_valid", 32'(md_req_valid), 0);
    chk("areset_in1", in1, 0);
    step(); step();
    reset = 0;
    step();
    lat_cfg = 0;
    issue(3'd4, 32'd9, 32'd3); wait_result("div_after_reset", 32'd3); step();
    // Randomized traffic against the model
    rdy_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      cmd_valid = $urandom_range(0, 9) < 7;
      cmd_funct3 = 3'($urandom);
      cmd_rs1 = pick();
      cmd_rs2 = pick();
      cmd_kill = $urandom_range(0, 19) == 0;
    end
    step();
    cmd_valid = 0; cmd_kill = 0;
    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
